pool_row_ctrl: RTL and testbench
================================

# pool_row_ctrl

Parametrised row/line sequencing controller for the pooling stage behind a convolution layer. It counts conv output pixels into lines and rows and steers each pixel into one of `POOL_H` pooling line buffers. It signals downstream when a pooling row group, either full or the partial group at the frame tail, is complete. Line length and row count are runtime-configurable up to compile-time maxima and are latched at layer start.

## Interface
- `MAX_LINE`, 12: maximum pixels per conv line.
- `MAX_ROW`, 25: maximum conv rows per frame.
- `POOL_H`, 2: pool window height, which is also the number of line buffers (≥1).
- `SEL_W`, $clog2(MAX_LINE): width of the column select.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `ConvValid_i`  in  1  layer active; low forces IDLE.
- `vbit_i`  in  1  one conv pixel valid this cycle.
- `LineLen_i`  in  $clog2(MAX_LINE+1)  pixels per line; sampled on IDLE→RUN.
- `RowNum_i`  in  $clog2(MAX_ROW+1)  rows per frame; sampled on IDLE→RUN.
- `PoolLineSel_o`  out  SEL_W  current column index (line counter).
- `PoolLineWe_o`  out  POOL_H  one-hot line-buffer write enable.
- `vbit_o`  out  1  registered pulse: a row group is complete.
- `PoolRows_o`  out  $clog2(POOL_H+1)  valid rows in the completed group; qualified by `vbit_o`.
- `RsZero_o`  out  1  registered pulse: last group of the frame; coincides with `vbit_o`.
- `CfgErr_o`  out  1  sticky flag: illegal configuration was clamped.

## Operation
- FSM states are IDLE and RUN.
  - IDLE→RUN when `ConvValid_i`=1. In the transition cycle the config is latched and `vbit_i` is ignored.
  - RUN→IDLE in the cycle after `ConvValid_i`=0 is seen. Counters clear to 0 on that edge.
- Config latch:
  - LineLen_i or RowNum_i equal to 0 or above its MAX → use the MAX value and set `CfgErr_o`.
  - `CfgErr_o` clears only at the next IDLE→RUN with a legal config, or on reset.
- Accept = RUN & `ConvValid_i` & `vbit_i`. Counters advance only on accept.
- LineCnt counts 0..LineLen-1. LineDone = (LineCnt==LineLen-1). It wraps to 0 on accept & LineDone.
- RowCnt advances on accept & LineDone. RowDone = (RowCnt==RowNum-1). It wraps to 0 at RowDone, and the next frame starts with the same config without returning to IDLE.
- GrpCnt counts 0..POOL_H-1 and advances on accept & LineDone. It wraps at POOL_H-1, and is forced to 0 on accept & LineDone & RowDone.
- `PoolLineWe_o`[GrpCnt] = accept. All other bits are 0. This output is combinational.
- `PoolLineSel_o` = LineCnt (register output).
- Group end = accept & LineDone & (GrpCnt==POOL_H-1 | RowDone). On group end, register `vbit_o`=1 and `PoolRows_o`=GrpCnt+1.
- `RsZero_o` is registered from accept & LineDone & RowDone.
- Arithmetic: all counters are unsigned and sized by the MAX parameters. No overflow is possible because wraps are compared against the latched values.

## Timing
- Reset values: `PoolLineSel_o`=0, `PoolLineWe_o`=0, `vbit_o`=0, `PoolRows_o`=0, `RsZero_o`=0, `CfgErr_o`=0. State resets to IDLE.
- Write enable: zero latency (same cycle as the pixel).
- `vbit_o`/`RsZero_o`: one cycle after the accepting pixel, one cycle wide.
- `PoolRows_o`: holds its value until the next group end.
- Back-to-back accepts at full rate are supported. Idle gaps (`vbit_i`=0) freeze all counters.
- `ConvValid_i` dropped mid-frame: pixels stop being accepted immediately. No `vbit_o` is issued for the partial group. Counters are 0 after the next edge.
- Frame wrap and a new frame's first pixel may be on consecutive cycles with no bubble.
- POOL_H=1: every line end is a group end, with `PoolRows_o`=1.
- Reset asserted mid-frame: all outputs go to reset values asynchronously.

## Structure
- Package `pool_ctrl_pkg` holds the IDLE/RUN state localparams and the width helper functions (clog2-based widths for the line, row, group and rows fields).
- Sub-module `wrap_cnt` is a generic enable/limit/clear counter with a terminal flag. It is instantiated three times: line, row and group.
- FSM, config clamp, one-hot decode and output registers stay in the top module.

## Test plan
- Defaults with LineLen=12, RowNum=25 and 300 contiguous pixels:
  - 12 `vbit_o` pulses with `PoolRows_o`=2.
  - A 13th pulse with `PoolRows_o`=1 and `RsZero_o`=1, one cycle after pixel 300.
  - `PoolLineWe_o` alternates 01/10 per line.
- LineLen=4, RowNum=6, POOL_H=3 with random `vbit_i` gaps:
  - `vbit_o` after pixels 12 and 24, each with `PoolRows_o`=3.
  - `RsZero_o` only with the second pulse.
  - `PoolLineSel_o` sequence is 0,1,2,3 repeated.
- LineLen_i=0 and RowNum_i=30 at start:
  - `CfgErr_o`=1 from the cycle after transition.
  - Frame runs 12×25.
  - Restart with legal config clears `CfgErr_o`.
- `ConvValid_i` low after 17 pixels:
  - No `vbit_o`.
  - Next cycle `PoolLineSel_o`=0.
  - Re-enable: the pixel in the transition cycle is ignored, and the next pixel writes `PoolLineWe_o`=01 at column 0.
- Two frames back-to-back:
  - Second frame's first pixel arrives in the cycle after the frame-end pixel.
  - `PoolLineWe_o`=01, column 0.
  - Second `RsZero_o` after 300 more pixels.
- `rstn` pulsed mid-group: all outputs read 0 during reset, and counting restarts from IDLE.

Source files
------------

// File: rtl/pool_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_ctrl_pkg
//  Description : Shared state encoding and field-width helpers for the
//                pooling row/line sequencing controller.
//  Contents    : ST_IDLE / ST_RUN state encodings, state_t,
//                cnt_w() (index field width), val_w() (count field width)
//  Revision    : 1.0  initial release
// ============================================================================
package pool_ctrl_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Bits needed to hold an index 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count 0..n (never narrower than one bit).
  function automatic int val_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_cnt
//  Description : Generic wrapping counter. Counts 0..i_last on i_en and
//                wraps to 0 after reaching i_last. i_clr has priority.
//  Ports       : clk, rstn      - clock, async active-low reset
//                i_clr          - synchronous clear to 0
//                i_en           - advance enable
//                i_last [W]     - terminal value
//                o_cnt  [W]     - current count
//                o_term         - count equals terminal value
//  Revision    : 1.0  initial release
// ============================================================================
module wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;
  logic         w_term;

  assign w_term = (r_cnt == i_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = w_term;

endmodule
`default_nettype wire

// File: rtl/pool_row_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pool_row_ctrl
//  Description : Row/line sequencing controller for the pooling stage.
//                Counts conv pixels into lines and rows, steers each pixel
//                to one of POOL_H line buffers and flags completed row
//                groups (full, or the partial group at the frame tail).
//  Ports       : clk, rstn        - clock, async active-low reset
//                ConvValid_i      - layer active (low returns to IDLE)
//                vbit_i           - conv pixel valid
//                LineLen_i        - pixels per line, sampled on IDLE->RUN
//                RowNum_i         - rows per frame, sampled on IDLE->RUN
//                PoolLineSel_o    - current column index
//                PoolLineWe_o     - one-hot line buffer write enable (comb)
//                vbit_o           - row group complete pulse
//                PoolRows_o       - valid rows in completed group
//                RsZero_o         - last group of frame pulse
//                CfgErr_o         - sticky: clamped illegal configuration
//  Revision    : 1.0  initial release
// ============================================================================
module pool_row_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int MAX_LINE = 12,
  parameter int MAX_ROW  = 25,
  parameter int POOL_H   = 2,
  parameter int SEL_W    = $clog2(MAX_LINE)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ConvValid_i,
  input  logic                        vbit_i,
  input  logic [$clog2(MAX_LINE+1)-1:0] LineLen_i,
  input  logic [$clog2(MAX_ROW+1)-1:0]  RowNum_i,
  output logic [SEL_W-1:0]            PoolLineSel_o,
  output logic [POOL_H-1:0]           PoolLineWe_o,
  output logic                        vbit_o,
  output logic [$clog2(POOL_H+1)-1:0] PoolRows_o,
  output logic                        RsZero_o,
  output logic                        CfgErr_o
);

  localparam int LEN_W  = $clog2(MAX_LINE + 1);
  localparam int RNUM_W = $clog2(MAX_ROW + 1);
  localparam int ROW_W  = cnt_w(MAX_ROW);
  localparam int GRP_W  = cnt_w(POOL_H);
  localparam int ROWS_W = $clog2(POOL_H + 1);

  localparam logic [GRP_W-1:0] C_GRP_LAST = GRP_W'(POOL_H - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_line_last;
  logic [ROW_W-1:0]   r_row_last;
  logic               r_cfg_err;
  logic               r_vbit;
  logic [ROWS_W-1:0]  r_rows;
  logic               r_rs_zero;

  logic               w_run;
  logic               w_acc;
  logic               w_clr;
  logic [SEL_W-1:0]   w_line_cnt;
  logic               w_line_done;
  logic               w_line_adv;
  logic [ROW_W-1:0]   w_row_cnt;
  logic               w_row_done;
  logic [GRP_W-1:0]   w_grp_cnt;
  logic               w_grp_term;
  logic               w_grp_end;
  logic               w_frame_end;

  logic               w_len_bad;
  logic               w_row_bad;
  logic [LEN_W-1:0]   w_len_m1;
  logic [RNUM_W-1:0]  w_row_m1;

  // Configuration clamp: zero or above-maximum falls back to the maximum.
  assign w_len_bad = (LineLen_i == '0) || (LineLen_i > LEN_W'(MAX_LINE));
  assign w_row_bad = (RowNum_i == '0)  || (RowNum_i > RNUM_W'(MAX_ROW));
  assign w_len_m1  = (w_len_bad ? LEN_W'(MAX_LINE) : LineLen_i) - LEN_W'(1);
  assign w_row_m1  = (w_row_bad ? RNUM_W'(MAX_ROW) : RowNum_i) - RNUM_W'(1);

  assign w_run       = (r_state == ST_RUN);
  assign w_acc       = w_run & ConvValid_i & vbit_i;
  // Counters sit at zero in IDLE and are cleared on the RUN->IDLE edge.
  assign w_clr       = ~w_run | ~ConvValid_i;
  assign w_line_adv  = w_acc & w_line_done;
  assign w_frame_end = w_line_adv & w_row_done;
  assign w_grp_end   = w_line_adv & (w_grp_term | w_row_done);

  wrap_cnt #(.W(SEL_W)) u_line_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_en   (w_acc),
    .i_last (r_line_last),
    .o_cnt  (w_line_cnt),
    .o_term (w_line_done)
  );

  wrap_cnt #(.W(ROW_W)) u_row_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_en   (w_line_adv),
    .i_last (r_row_last),
    .o_cnt  (w_row_cnt),
    .o_term (w_row_done)
  );

  // Group counter restarts at every frame end so the next frame's first
  // line always lands in buffer 0, even after a partial tail group.
  wrap_cnt #(.W(GRP_W)) u_grp_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr | w_frame_end),
    .i_en   (w_line_adv),
    .i_last (C_GRP_LAST),
    .o_cnt  (w_grp_cnt),
    .o_term (w_grp_term)
  );

  generate
    for (genvar gi = 0; gi < POOL_H; gi++) begin : g_we
      assign PoolLineWe_o[gi] = w_acc & (w_grp_cnt == GRP_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_line_last <= SEL_W'(MAX_LINE - 1);
      r_row_last  <= ROW_W'(MAX_ROW - 1);
      r_cfg_err   <= 1'b0;
      r_vbit      <= 1'b0;
      r_rows      <= '0;
      r_rs_zero   <= 1'b0;
    end else begin
      r_vbit    <= w_grp_end;
      r_rs_zero <= w_frame_end;
      if (w_grp_end) begin
        r_rows <= ROWS_W'(w_grp_cnt) + ROWS_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (ConvValid_i) begin
            r_state     <= ST_RUN;
            r_line_last <= SEL_W'(w_len_m1);
            r_row_last  <= ROW_W'(w_row_m1);
            r_cfg_err   <= w_len_bad | w_row_bad;
          end
        end
        ST_RUN: begin
          if (!ConvValid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PoolLineSel_o = w_line_cnt;
  assign vbit_o        = r_vbit;
  assign PoolRows_o    = r_rows;
  assign RsZero_o      = r_rs_zero;
  assign CfgErr_o      = r_cfg_err;

  // Row counter value is only needed through its terminal flag.
  logic w_unused;
  assign w_unused = ^w_row_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pool_row_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_row_ctrl
//  Description : Self-checking bench for pool_row_ctrl. Two instances
//                (POOL_H=2 and POOL_H=3) share stimulus; an index-based
//                frame model predicts write enables, column select and
//                group events, which are queued and matched on output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pool_row_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cv = 1'b0;
  logic       vb = 1'b0;
  logic [3:0] len_i = 4'd12;
  logic [4:0] row_i = 5'd25;

  logic [3:0] sel_a, sel_b;
  logic [1:0] we_a;
  logic [2:0] we_b;
  logic       v_a, v_b, rs_a, rs_b, err_a, err_b;
  logic [1:0] rows_a, rows_b;

  always #5 clk = ~clk;

  pool_row_ctrl #(.MAX_LINE(12), .MAX_ROW(25), .POOL_H(2)) dut_a (
    .clk(clk), .rstn(rstn), .ConvValid_i(cv), .vbit_i(vb),
    .LineLen_i(len_i), .RowNum_i(row_i),
    .PoolLineSel_o(sel_a), .PoolLineWe_o(we_a), .vbit_o(v_a),
    .PoolRows_o(rows_a), .RsZero_o(rs_a), .CfgErr_o(err_a)
  );

  pool_row_ctrl #(.MAX_LINE(12), .MAX_ROW(25), .POOL_H(3)) dut_b (
    .clk(clk), .rstn(rstn), .ConvValid_i(cv), .vbit_i(vb),
    .LineLen_i(len_i), .RowNum_i(row_i),
    .PoolLineSel_o(sel_b), .PoolLineWe_o(we_b), .vbit_o(v_b),
    .PoolRows_o(rows_b), .RsZero_o(rs_b), .CfgErr_o(err_b)
  );

  typedef struct {
    int cyc;
    int rows;
    bit rs;
  } ev_t;

  typedef struct {
    logic [3:0] len;
    logic [4:0] row;
    bit         exp_err;
    int         exp_len;
    int         exp_row;
  } cfg_vec_t;

  ev_t q_a[$];
  ev_t q_b[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  pulses[2];
  int  rs_cnt[2];
  int  last_rs[2];
  int  hold[2];

  // Frame model: pixel index within the current frame.
  bit  m_run = 0;
  bit  m_err = 0;
  int  m_L = 12;
  int  m_R = 25;
  int  m_p = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0;
      rs_cnt[k] = 0;
      last_rs[k] = -1;
    end
  endtask

  task automatic model_edge(input logic c, input logic v);
    int col, row;
    ev_t e;
    cyc++;
    if (!m_run) begin
      if (c) begin
        m_run = 1;
        m_p   = 0;
        m_err = 0;
        if (len_i == 0 || len_i > 12) begin m_L = 12; m_err = 1; end
        else m_L = int'(len_i);
        if (row_i == 0 || row_i > 25) begin m_R = 25; m_err = 1; end
        else m_R = int'(row_i);
      end
    end else if (!c) begin
      m_run = 0;
      m_p   = 0;
    end else if (v) begin
      col = m_p % m_L;
      row = m_p / m_L;
      if (col == m_L - 1) begin
        if (row % 2 == 1 || row == m_R - 1) begin
          e.cyc = cyc; e.rows = row % 2 + 1; e.rs = (row == m_R - 1);
          q_a.push_back(e);
        end
        if (row % 3 == 2 || row == m_R - 1) begin
          e.cyc = cyc; e.rows = row % 3 + 1; e.rs = (row == m_R - 1);
          q_b.push_back(e);
        end
      end
      m_p = (m_p + 1) % (m_L * m_R);
    end
  endtask

  task automatic check_grp(input int k, input logic v, input logic [1:0] rows, input logic rs);
    ev_t e;
    bit  have;
    have = 0;
    if (k == 0 && q_a.size() > 0) begin have = 1; e = q_a[0]; end
    if (k == 1 && q_b.size() > 0) begin have = 1; e = q_b[0]; end
    if (v === 1'b1) begin
      if (!have) begin
        n_checks++;
        n_errors++;
        $display("FAIL vbit_unexpected%0d: got vbit=1 required 0 (cycle %0d)", k, cyc);
      end else begin
        if (k == 0) q_a.delete(0); else q_b.delete(0);
        chk($sformatf("vbit_cycle%0d", k), cyc, e.cyc);
        chk($sformatf("pool_rows%0d", k), rows, e.rows);
        chk($sformatf("rs_zero%0d", k), rs, e.rs);
        hold[k] = e.rows;
        pulses[k]++;
        if (rs === 1'b1) begin rs_cnt[k]++; last_rs[k] = cyc; end
      end
    end else begin
      chk($sformatf("vbit_level%0d", k), v, 0);
      chk($sformatf("rs_without_vbit%0d", k), rs, 0);
      chk($sformatf("rows_hold%0d", k), rows, hold[k]);
      if (have && e.cyc <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL vbit_missed%0d: got vbit=0 required 1 rows=%0d (cycle %0d)", k, e.rows, cyc);
        if (k == 0) q_a.delete(0); else q_b.delete(0);
      end
    end
  endtask

  // One clock: drive, check combinational outputs, clock, check registered.
  task automatic step(input logic c, input logic v);
    int row, exp_sel, exp_wa, exp_wb;
    bit acc;
    cv = c;
    vb = v;
    #3;
    acc     = m_run && c && v;
    row     = m_run ? m_p / m_L : 0;
    exp_sel = m_run ? m_p % m_L : 0;
    exp_wa  = acc ? (1 << (row % 2)) : 0;
    exp_wb  = acc ? (1 << (row % 3)) : 0;
    chk("line_sel_a", sel_a, exp_sel);
    chk("line_sel_b", sel_b, exp_sel);
    chk("line_we_a", we_a, exp_wa);
    chk("line_we_b", we_b, exp_wb);
    @(posedge clk);
    model_edge(c, v);
    #1;
    check_grp(0, v_a, rows_a, rs_a);
    check_grp(1, v_b, rows_b, rs_b);
    chk("cfg_err_a", err_a, m_err);
    chk("cfg_err_b", err_b, m_err);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sel_a", sel_a, 0);
    chk("rst_sel_b", sel_b, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_we_b", we_b, 0);
    chk("rst_vbit_a", v_a, 0);
    chk("rst_vbit_b", v_b, 0);
    chk("rst_rows_a", rows_a, 0);
    chk("rst_rows_b", rows_b, 0);
    chk("rst_rs_a", rs_a, 0);
    chk("rst_rs_b", rs_b, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_err_b", err_b, 0);
  endtask

  task automatic model_reset();
    m_run = 0; m_p = 0; m_err = 0;
    hold[0] = 0; hold[1] = 0;
    q_a.delete();
    q_b.delete();
  endtask

  // Asynchronous reset asserted between clock edges with a live pixel.
  task automatic rst_pulse();
    cv = 1'b1;
    vb = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    cv = 1'b0;
    vb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic start(input logic [3:0] l, input logic [4:0] r);
    step(1'b0, 1'b0);
    len_i = l;
    row_i = r;
    step(1'b1, 1'b1);   // transition cycle: pixel ignored
    clear_stats();
  endtask

  cfg_vec_t tbl[5];

  initial begin
    tbl[0] = '{len: 4'd0,  row: 5'd30, exp_err: 1'b1, exp_len: 12, exp_row: 25};
    tbl[1] = '{len: 4'd4,  row: 5'd6,  exp_err: 1'b0, exp_len: 4,  exp_row: 6};
    tbl[2] = '{len: 4'd13, row: 5'd25, exp_err: 1'b1, exp_len: 12, exp_row: 25};
    tbl[3] = '{len: 4'd12, row: 5'd0,  exp_err: 1'b1, exp_len: 12, exp_row: 25};
    tbl[4] = '{len: 4'd5,  row: 5'd3,  exp_err: 1'b0, exp_len: 5,  exp_row: 3};

    clear_stats();
    model_reset();
    #2;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Defaults, two frames back-to-back (600 contiguous pixels).
    start(4'd12, 5'd25);
    for (int i = 0; i < 600; i++) step(1'b1, 1'b1);
    chk("dflt_pulses_a", pulses[0], 26);
    chk("dflt_rs_a", rs_cnt[0], 2);
    chk("dflt_pulses_b", pulses[1], 18);
    chk("dflt_rs_b", rs_cnt[1], 2);

    // 4x6 frame with random idle gaps.
    start(4'd4, 5'd6);
    begin
      int n;
      n = 0;
      for (int i = 0; i < 400 && n < 24; i++) begin
        logic g;
        g = 1'($urandom_range(0, 1));
        step(1'b1, g);
        if (g) n++;
      end
      chk("gap_pixels", n, 24);
    end
    chk("gap_pulses_b", pulses[1], 2);
    chk("gap_rs_b", rs_cnt[1], 1);
    chk("gap_pulses_a", pulses[0], 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Configuration clamp table: each entry runs one full effective frame.
    for (int t = 0; t < 5; t++) begin
      start(tbl[t].len, tbl[t].row);
      chk($sformatf("tbl%0d_cfg_err", t), err_a, tbl[t].exp_err);
      for (int i = 0; i < tbl[t].exp_len * tbl[t].exp_row; i++) step(1'b1, 1'b1);
      chk($sformatf("tbl%0d_rs_count", t), rs_cnt[0], 1);
      chk($sformatf("tbl%0d_rs_at_end", t), last_rs[0], cyc);
    end

    // ConvValid dropped after 17 pixels, then re-enabled.
    start(4'd12, 5'd25);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("drop_no_vbit", pulses[0], 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    chk("drop_resume_pulses", pulses[0], 1);

    // Reset mid-group, then restart from IDLE.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    rst_pulse();
    step(1'b0, 1'b0);
    start(4'd12, 5'd25);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1);
    chk("post_rst_pulses", pulses[0], 1);
    step(1'b1, 1'b0);

    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
